// File: rtl/bcd_pkg.sv
// Shared constants for the cascaded BCD counter: digit width and the
// default terminal value of a single decimal digit.
package bcd_pkg;

  localparam int DIGIT_W       = 4;
  localparam int DIGIT_MAX_DEF = 9;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter chain. The digit steps when step_in is
// high, rolls over at its range ends and tells the next digit to step
// through step_out. Loads are clamped to the digit's legal range.
module bcd_digit
  import bcd_pkg::*;
#(
  parameter int DIGIT_MAX = DIGIT_MAX_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               step_in,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               sat_hold,
  output logic [DIGIT_W-1:0] digit,
  output logic               step_out
);

  localparam digit_t MAX_D = digit_t'(DIGIT_MAX);

  // Out-of-range load digits are pinned to the top of the digit range.
  function automatic digit_t clamp_digit(input digit_t d);
    return (d > MAX_D) ? MAX_D : d;
  endfunction

  logic at_end;

  // Digit sits at the end of its range for the current direction.
  always_comb begin
    at_end = up ? (digit == MAX_D) : (digit == '0);
  end

  // Carry/borrow to the next digit depends only on the registered digit,
  // so the chain never loops back through count.
  assign step_out = step_in & at_end;

  // Digit register: reset > load > step (unless the chain is saturated) > hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      digit <= '0;
    end else if (load) begin
      digit <= clamp_digit(load_digit);
    end else if (step_in && !sat_hold) begin
      if (up) begin
        digit <= at_end ? '0 : digit + digit_t'(1);
      end else begin
        digit <= at_end ? MAX_D : digit - digit_t'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_counter_chain.sv
// Cascaded up/down BCD counter with load, wrap or saturate at the range
// ends, a combinational terminal-count flag and a registered wrap pulse.
module bcd_counter_chain
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_MAX  = DIGIT_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic                        up,
  input  logic                        sat,
  input  logic                        load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                        tc,
  output logic                        wrap
);

  localparam digit_t MAX_D = digit_t'(DIGIT_MAX);

  // step[i] is the step request into digit i; step[NUM_DIGITS] means the
  // whole chain is at its terminal value while enabled.
  logic [NUM_DIGITS:0]   step;
  logic [NUM_DIGITS-1:0] at_term;
  logic                  sat_hold;

  assign step[0] = en;

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
      assign at_term[i] = up ? (count[i*DIGIT_W +: DIGIT_W] == MAX_D)
                             : (count[i*DIGIT_W +: DIGIT_W] == '0);

      bcd_digit #(
        .DIGIT_MAX (DIGIT_MAX)
      ) u_digit (
        .clk        (clk),
        .rstn       (rstn),
        .step_in    (step[i]),
        .up         (up),
        .load       (load),
        .load_digit (load_val[i*DIGIT_W +: DIGIT_W]),
        .sat_hold   (sat_hold),
        .digit      (count[i*DIGIT_W +: DIGIT_W]),
        .step_out   (step[i+1])
      );
    end
  endgenerate

  // Terminal value is decoded from the registered count and the live up
  // input only; en does not gate it.
  assign tc       = &at_term;
  assign sat_hold = sat & tc;

  // Wrap flag: set only by an enabled, non-saturating step from terminal.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrap <= 1'b0;
    end else begin
      wrap <= ~load & step[NUM_DIGITS] & ~sat;
    end
  end

endmodule

// File: tb/tb_bcd_counter_chain.sv
module tb_bcd_counter_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 4 digits, 0..9 each
  logic        rstn, en, up, sat, load;
  logic [15:0] load_val, count;
  logic        tc, wrap;

  // Base-6 instance: 2 digits, 0..5 each
  logic        rstn2, en2, up2, sat2, load2;
  logic [7:0]  load_val2, count2;
  logic        tc2, wrap2;

  bcd_counter_chain #(.NUM_DIGITS(4), .DIGIT_MAX(9)) dut (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
  );

  bcd_counter_chain #(.NUM_DIGITS(2), .DIGIT_MAX(5)) dut2 (
    .clk(clk), .rstn(rstn2), .en(en2), .up(up2), .sat(sat2), .load(load2),
    .load_val(load_val2), .count(count2), .tc(tc2), .wrap(wrap2)
  );

  typedef struct {
    logic [15:0] cnt;
    logic        tcv;
    logic        wrp;
    string       nm;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic logic term1(input logic [15:0] c, input logic u);
    return u ? (c == 16'h9999) : (c == 16'h0000);
  endfunction

  function automatic logic term2(input logic [7:0] c, input logic u);
    return u ? (c == 8'h55) : (c == 8'h00);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Drive one cycle of inputs on the falling edge; after the rising edge
  // queue the state the counter must show.
  task automatic drv1(input logic r, input logic l, input logic e, input logic u,
                      input logic s, input logic [15:0] lv,
                      input logic [15:0] ec, input logic ew, input string nm);
    exp_t x;
    @(negedge clk);
    rstn = r; load = l; en = e; up = u; sat = s; load_val = lv;
    @(posedge clk);
    x.cnt = ec; x.tcv = term1(ec, u); x.wrp = ew; x.nm = nm;
    q1.push_back(x);
  endtask

  task automatic drv2(input logic r, input logic l, input logic e, input logic u,
                      input logic s, input logic [7:0] lv,
                      input logic [7:0] ec, input logic ew, input string nm);
    exp_t x;
    @(negedge clk);
    rstn2 = r; load2 = l; en2 = e; up2 = u; sat2 = s; load_val2 = lv;
    @(posedge clk);
    x.cnt = {8'h00, ec}; x.tcv = term2(ec, u); x.wrp = ew; x.nm = nm;
    q2.push_back(x);
  endtask

  // Monitors: sample just after each rising edge, while inputs are stable.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk({e.nm, ".count"}, count, e.cnt);
        chk({e.nm, ".tc"}, {15'd0, tc}, {15'd0, e.tcv});
        chk({e.nm, ".wrap"}, {15'd0, wrap}, {15'd0, e.wrp});
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk({e.nm, ".count2"}, {8'h00, count2}, e.cnt);
        chk({e.nm, ".tc2"}, {15'd0, tc2}, {15'd0, e.tcv});
        chk({e.nm, ".wrap2"}, {15'd0, wrap2}, {15'd0, e.wrp});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: stimulus did not complete, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    rstn2 = 1'b0; en2 = 1'b0; up2 = 1'b1; sat2 = 1'b0; load2 = 1'b0; load_val2 = '0;

    // Reset overrides load and en; tc follows up straight after reset
    drv1(0, 1, 1, 1, 0, 16'h1234, 16'h0000, 0, "rst_ovr");
    drv1(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, "rst_down_tc");

    // Full up-count: 0001 .. 9999 then wrap to 0000 with one wrap pulse
    for (int i = 1; i <= 10000; i++)
      drv1(1, 0, 1, 1, 0, 16'h0000, to_bcd(i % 10000), (i == 10000), "run_up");
    drv1(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, "hold_after_wrap");

    // Down count with borrow across digits
    drv1(1, 1, 0, 0, 0, 16'h0100, 16'h0100, 0, "load_0100");
    drv1(1, 0, 1, 0, 0, 16'h0000, 16'h0099, 0, "dn_borrow");
    drv1(1, 0, 1, 0, 0, 16'h0000, 16'h0098, 0, "dn_step");

    // Saturate at zero going down, then release to wrap
    drv1(1, 1, 1, 0, 1, 16'h0000, 16'h0000, 0, "load_zero");
    for (int i = 0; i < 5; i++)
      drv1(1, 0, 1, 0, 1, 16'h0000, 16'h0000, 0, "sat_dn_hold");
    drv1(1, 0, 1, 0, 0, 16'h0000, 16'h9999, 1, "wrap_dn");
    drv1(1, 0, 1, 1, 1, 16'h0000, 16'h9999, 0, "sat_up_hold");

    // Load clamping and load priority over en
    drv1(1, 1, 0, 1, 0, 16'h00F7, 16'h0097, 0, "clamp_f7");
    drv1(1, 1, 1, 1, 0, 16'h1234, 16'h1234, 0, "load_wins");
    drv1(1, 0, 1, 1, 0, 16'h0000, 16'h1235, 0, "up_step");
    drv1(1, 0, 1, 0, 0, 16'h0000, 16'h1234, 0, "dir_change");
    drv1(1, 1, 0, 0, 0, 16'hA0B5, 16'h9095, 0, "clamp_mix");
    drv1(1, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, "load_1000");
    drv1(1, 0, 1, 0, 0, 16'h0000, 16'h0999, 0, "borrow_chain");

    // Wrap up, then a load clears the pulse
    drv1(1, 1, 0, 1, 0, 16'h9999, 16'h9999, 0, "load_top");
    drv1(1, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, "wrap_up");
    drv1(1, 1, 0, 1, 0, 16'h0005, 16'h0005, 0, "load_clr_wrap");

    // Reset mid-count with load high, then resume from zero
    drv1(1, 1, 0, 1, 0, 16'h0040, 16'h0040, 0, "load_0040");
    drv1(1, 0, 1, 1, 0, 16'h0000, 16'h0041, 0, "mid_step1");
    drv1(1, 0, 1, 1, 0, 16'h0000, 16'h0042, 0, "mid_step2");
    drv1(0, 1, 1, 1, 0, 16'h5555, 16'h0000, 0, "rst_mid");
    drv1(1, 0, 1, 1, 0, 16'h0000, 16'h0001, 0, "resume");

    // Reset clears a pending wrap pulse
    drv1(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, "load_zero2");
    drv1(1, 0, 1, 0, 0, 16'h0000, 16'h9999, 1, "wrap_dn2");
    drv1(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, "rst_clr_wrap");

    // Base-6, two-digit chain: 36 steps from 00 back to 00
    drv2(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, "rst2");
    for (int i = 1; i <= 36; i++)
      drv2(1, 0, 1, 1, 0, 8'h00, {4'(i % 36 / 6), 4'(i % 36 % 6)}, (i == 36), "run6");
    drv2(1, 1, 0, 1, 0, 8'h9F, 8'h55, 0, "clamp2");
    drv2(1, 0, 1, 1, 1, 8'h00, 8'h55, 0, "sat2");
    drv2(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, "load2_zero");
    drv2(1, 0, 1, 0, 0, 8'h00, 8'h55, 1, "wrap2_dn");

    repeat (3) @(posedge clk);
    #3;
    chk("q1_drained", 16'(q1.size()), 16'd0);
    chk("q2_drained", 16'(q2.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_counter_chain.md
BCD_COUNTER_CHAIN -- requirements
Module: bcd_counter_chain

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of cascaded decimal digits, legal range 1..8.
REQ-002 SHALL have parameter DIGIT_MAX, default 9: terminal value of each digit, legal range 1..15.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable; one step per cycle while high.
REQ-006 SHALL have port up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 SHALL have port sat  input  1  mode: 0 wraps at the end of the range, 1 saturates there.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  4*NUM_DIGITS  load value, digit 0 in bits [3:0].
REQ-010 SHALL have port count  output  4*NUM_DIGITS  registered count, digit 0 least significant.
REQ-011 SHALL have port tc  output  1  combinational: high when count is at the terminal value for the current up.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse flagging that the previous edge wrapped.

Function
REQ-013 SHALL give each digit the range 0..DIGIT_MAX; total range 0..(DIGIT_MAX+1)^NUM_DIGITS-1.
REQ-014 SHALL apply priority per edge: rstn low > load > en > hold.
REQ-015 SHALL, with load high, set count to load_val on the next edge regardless of en, clamping any digit above DIGIT_MAX to DIGIT_MAX.
REQ-016 SHALL, with en high and up=1, increment digit 0; a digit at DIGIT_MAX receiving a carry goes to 0 and carries to the next digit.
REQ-017 SHALL, with en high and up=0, decrement digit 0; a digit at 0 receiving a borrow goes to DIGIT_MAX and borrows from the next digit.
REQ-018 SHALL define the terminal value as all digits DIGIT_MAX when up=1, or all digits 0 when up=0; tc reflects this in the same cycle, gated by nothing.
REQ-019 SHALL, with en high, tc high and sat=0, wrap on the next edge: all digits 0 when counting up, all DIGIT_MAX when counting down; wrap is high for exactly the following cycle.
REQ-020 SHALL, with en high, tc high and sat=1, hold count unchanged; wrap stays low.
REQ-021 SHALL drive wrap low on any cycle following a load, a hold, a reset or a non-wrapping step.
REQ-022 SHALL apply a direction change on the same edge it is sampled; there is no turnaround latency.
REQ-023 SHALL produce the count 1 edge after en/load is sampled; single-cycle latency.

Reset
REQ-024 SHALL, with rstn low at an edge, clear count to 0 and wrap to 0, overriding load and en.
REQ-025 SHALL abort any step in progress when reset is asserted mid-count; counting resumes from 0 on the first edge with rstn high and en high.
REQ-026 SHALL drive tc combinationally after reset: high if up=0, since 0 is the down terminal value.

Structure
REQ-027 SHALL place DIGIT_W (=4) and the default DIGIT_MAX in the shared package bcd_pkg.
REQ-028 SHALL instantiate NUM_DIGITS copies of sub-module bcd_digit, each with ports clk, rstn, step_in, up, load, load_digit, sat_hold, digit, step_out.
REQ-029 SHALL generate the carry/borrow chain and the saturate-hold decode in the top level, with no combinational loop through count.

Verification
REQ-030 SHALL cover: reset, then en=1, up=1, sat=0 for 10000 cycles with NUM_DIGITS=4 -> count 9999 then 0000; wrap pulses once, on the cycle after the 9999->0000 edge.
REQ-031 SHALL cover: load 0x0100, up=0, en=1 -> next edges give 0x0099, then 0x0098; no wrap.
REQ-032 SHALL cover: load 0x0000, up=0, sat=1, en=1 for 5 cycles -> count stays 0x0000, tc=1, wrap=0; then sat=0 -> count 0x9999, wrap pulses.
REQ-033 SHALL cover: load_val 0x00F7 -> count 0x0097 (clamped digit); load and en both high -> load wins.
REQ-034 SHALL cover: count at 0x0042 mid-count, rstn low one edge while load high -> count 0x0000, wrap 0; en held -> 0x0001 on the next edge.
REQ-035 SHALL cover: DIGIT_MAX=5, NUM_DIGITS=2, up=1 from 0 -> sequence wraps 0x55->0x00 after 36 steps.
